// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the fetch requester (i_*), load/store requester (d_*), the
//   single-ported memory port (m_*) and the busy flag used by
//   mem_port_arbiter.
//   slave  : the arbiter's view (requests and m_rdata in; grants, read
//            returns, memory command and busy out).
//   master : the view of the core requesters together with the memory.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_rdata;

    logic        busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               m_en, m_we, m_addr, m_wdata, m_be, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               m_en, m_we, m_addr, m_wdata, m_be, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported word-wide memory between instruction fetch (I)
//   and load/store (D). One transaction at a time; D has priority unless I
//   has waited through STARVE_MAX consecutive D grants. Stores complete at
//   issue; reads wait MEM_LAT cycles and return data with a one-cycle
//   rvalid pulse to the requester that issued them.
// Ports
//   clk    : clock, rising edge
//   rst_b  : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.slave (requests, grants, read returns,
//            memory command port, busy)
// Parameters
//   MEM_LAT    : issue-to-m_rdata latency in cycles, 1..4
//   STARVE_MAX : consecutive D grants tolerated while I waits, >= 1
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned LW = 3;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          owner_i_q, owner_i_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;

    logic pick_i, pick_d, rd_issue, rd_done;
    logic unused_addr_lsbs;

    // Arbitration is combinational on this cycle's requests. Grants are
    // suppressed while reset is asserted so every output reads 0 then.
    always_comb begin
        pick_i = 1'b0;
        pick_d = 1'b0;
        if (rst_b && state_q == IDLE) begin
            if (bus.i_req && (!bus.d_req || starve_q == SW'(STARVE_MAX))) begin
                pick_i = 1'b1;
            end else if (bus.d_req) begin
                pick_d = 1'b1;
            end
        end
    end

    assign rd_issue = pick_i || (pick_d && !bus.d_we);
    assign rd_done  = (state_q == RD_WAIT) && (lat_q == LW'(MEM_LAT));

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        owner_i_d = owner_i_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        starve_d  = starve_q;

        case (state_q)
            IDLE: begin
                if (rd_issue) begin
                    state_d   = RD_WAIT;
                    lat_d     = LW'(1);
                    owner_i_d = pick_i;
                end
            end
            RD_WAIT: begin
                if (rd_done) begin
                    state_d = IDLE;
                    if (owner_i_q) begin
                        i_rdata_d = bus.m_rdata;
                    end else begin
                        d_rdata_d = bus.m_rdata;
                    end
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Counts D wins over a waiting fetch; any cycle without a fetch
        // request, or a fetch grant, forgives the backlog.
        if (!bus.i_req || pick_i) begin
            starve_d = '0;
        end else if (pick_d && starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            starve_q  <= '0;
            owner_i_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            starve_q  <= starve_d;
            owner_i_q <= owner_i_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign bus.i_gnt   = pick_i;
    assign bus.d_gnt   = pick_d;
    assign bus.m_en    = pick_i || pick_d;
    assign bus.m_we    = pick_d && bus.d_we;
    assign bus.m_addr  = pick_i ? {bus.i_addr[31:2], 2'b00} :
                         pick_d ? {bus.d_addr[31:2], 2'b00} : '0;
    assign bus.m_wdata = (pick_d && bus.d_we) ? bus.d_wdata : '0;
    assign bus.m_be    = (pick_d && bus.d_we) ? bus.d_be    : '0;
    assign bus.busy    = (state_q == RD_WAIT);

    // rvalid is decoded from registered state so the pulse lands in the
    // same cycle m_rdata is valid; rdata shows m_rdata during that pulse
    // and the captured copy afterwards.
    assign bus.i_rvalid = rd_done && owner_i_q;
    assign bus.d_rvalid = rd_done && !owner_i_q;
    assign bus.i_rdata  = bus.i_rvalid ? bus.m_rdata : i_rdata_q;
    assign bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : d_rdata_q;

    assign unused_addr_lsbs = ^{bus.i_addr[1:0], bus.d_addr[1:0]};
endmodule
